// File: rtl/dma_xfer_sequencer.sv
// Single-transfer engine for the I8237-style controller: arbitrates four DREQ lines,
// runs DACK + one memory cycle, then hands the new address/count back to the register file.
module dma_xfer_sequencer #(
    parameter int ADR_W = 24,
    parameter int CNT_W = 16
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iEn,
    input  logic                 iRotate,
    input  logic [3:0]           iDreq,
    input  logic [3:0]           iMask,
    input  logic [7:0]           iDir,
    input  logic [3:0]           iDec,
    input  logic [4*ADR_W-1:0]   iAdrAll,
    input  logic [4*CNT_W-1:0]   iCntAll,
    output logic [3:0]           oDack,
    output logic                 oUpdStb,
    output logic [1:0]           oUpdCh,
    output logic [ADR_W-1:0]     oUpdAdr,
    output logic [CNT_W-1:0]     oUpdCnt,
    output logic [3:0]           oTc,
    output logic [ADR_W-1:0]     oMemAdr,
    output logic [1:0]           oMemRW,
    output logic [7:0]           oMemData,
    input  logic [7:0]           iMemData,
    input  logic                 iMemAck,
    input  logic [7:0]           iIoData,
    output logic [7:0]           oIoData,
    output logic                 oIoStb
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_MEM,
        ST_UPDATE
    } state_t;

    localparam logic [1:0] DIR_DEV2MEM = 2'b01;
    localparam logic [1:0] DIR_MEM2DEV = 2'b10;

    state_t             state_q;
    state_t             state_d;
    logic [1:0]         ch_q;
    logic [ADR_W-1:0]   adr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         dir_q;
    logic               dec_q;
    logic [1:0]         pri_hi_q;
    logic [7:0]         mem_data_q;
    logic [7:0]         io_data_q;
    logic               io_stb_q;

    logic [3:0]         req;
    logic [1:0]         base;
    logic [1:0]         idx;
    logic [1:0]         win_ch;
    logic               win_valid;
    logic [ADR_W-1:0]   adr_ch [4];
    logic [CNT_W-1:0]   cnt_ch [4];
    logic [1:0]         dir_ch [4];
    logic [15:0]        new_off;
    logic               in_upd;
    logic               is_mem_dir;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            adr_ch[i] = iAdrAll[i*ADR_W +: ADR_W];
            cnt_ch[i] = iCntAll[i*CNT_W +: CNT_W];
            dir_ch[i] = iDir[i*2 +: 2];
        end
    end

    // Scan starts at channel 0 (fixed) or at the rotation pointer; first requester wins.
    always_comb begin
        req       = iEn ? (iDreq & ~iMask) : 4'b0000;
        base      = iRotate ? pri_hi_q : 2'd0;
        idx       = 2'd0;
        win_ch    = 2'd0;
        win_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = base + 2'(i);
            if (!win_valid && req[idx]) begin
                win_valid = 1'b1;
                win_ch    = idx;
            end
        end
    end

    assign is_mem_dir = (dir_q == DIR_DEV2MEM) || (dir_q == DIR_MEM2DEV);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (win_valid) state_d = ST_GRANT;
            ST_GRANT:  state_d = is_mem_dir ? ST_MEM : ST_UPDATE;
            ST_MEM:    if (iMemAck) state_d = ST_UPDATE;
            ST_UPDATE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q    <= ST_IDLE;
            ch_q       <= 2'd0;
            adr_q      <= '0;
            cnt_q      <= '0;
            dir_q      <= 2'd0;
            dec_q      <= 1'b0;
            pri_hi_q   <= 2'd0;
            mem_data_q <= 8'h00;
            io_data_q  <= 8'h00;
            io_stb_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            io_stb_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win_valid) begin
                        ch_q  <= win_ch;
                        adr_q <= adr_ch[win_ch];
                        cnt_q <= cnt_ch[win_ch];
                        dir_q <= dir_ch[win_ch];
                        dec_q <= iDec[win_ch];
                    end
                end
                ST_GRANT: begin
                    if (dir_q == DIR_DEV2MEM) mem_data_q <= iIoData;
                end
                ST_MEM: begin
                    if (iMemAck && dir_q == DIR_MEM2DEV) begin
                        io_data_q <= iMemData;
                        io_stb_q  <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    if (iRotate) pri_hi_q <= ch_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Only the 16-bit offset steps; the page byte above it is carried through untouched.
    assign new_off = dec_q ? (adr_q[15:0] - 16'd1) : (adr_q[15:0] + 16'd1);
    assign in_upd  = (state_q == ST_UPDATE);

    assign oDack    = (state_q != ST_IDLE) ? (4'b0001 << ch_q) : 4'b0000;
    assign oUpdStb  = in_upd;
    assign oUpdCh   = in_upd ? ch_q : 2'd0;
    assign oUpdAdr  = in_upd ? {adr_q[ADR_W-1:16], new_off} : '0;
    assign oUpdCnt  = in_upd ? (cnt_q - CNT_W'(1)) : '0;
    assign oTc      = (in_upd && cnt_q == '0) ? (4'b0001 << ch_q) : 4'b0000;
    assign oMemAdr  = (state_q == ST_MEM) ? adr_q : '0;
    assign oMemRW   = (state_q == ST_MEM) ? ((dir_q == DIR_DEV2MEM) ? 2'b01 : 2'b10) : 2'b00;
    assign oMemData = mem_data_q;
    assign oIoData  = io_data_q;
    assign oIoStb   = io_stb_q;

endmodule

// File: tb/tb_dma_xfer_sequencer.sv
// Directed bench for dma_xfer_sequencer: each task drives one scenario and checks
// hand-computed values one cycle at a time.
module tb_dma_xfer_sequencer;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iEn;
    logic        iRotate;
    logic [3:0]  iDreq;
    logic [3:0]  iMask;
    logic [7:0]  iDir;
    logic [3:0]  iDec;
    logic [95:0] iAdrAll;
    logic [63:0] iCntAll;
    logic [3:0]  oDack;
    logic        oUpdStb;
    logic [1:0]  oUpdCh;
    logic [23:0] oUpdAdr;
    logic [15:0] oUpdCnt;
    logic [3:0]  oTc;
    logic [23:0] oMemAdr;
    logic [1:0]  oMemRW;
    logic [7:0]  oMemData;
    logic [7:0]  iMemData;
    logic        iMemAck;
    logic [7:0]  iIoData;
    logic [7:0]  oIoData;
    logic        oIoStb;

    int n_checks = 0;
    int n_fail   = 0;

    dma_xfer_sequencer #(.ADR_W(24), .CNT_W(16)) dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iRotate(iRotate),
        .iDreq(iDreq), .iMask(iMask), .iDir(iDir), .iDec(iDec),
        .iAdrAll(iAdrAll), .iCntAll(iCntAll),
        .oDack(oDack), .oUpdStb(oUpdStb), .oUpdCh(oUpdCh), .oUpdAdr(oUpdAdr),
        .oUpdCnt(oUpdCnt), .oTc(oTc), .oMemAdr(oMemAdr), .oMemRW(oMemRW),
        .oMemData(oMemData), .iMemData(iMemData), .iMemAck(iMemAck),
        .iIoData(iIoData), .oIoData(oIoData), .oIoStb(oIoStb)
    );

    always #5 iClk = ~iClk;

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic applyStimulus(input int ch, input logic [23:0] adr, input logic [15:0] cnt,
                                 input logic [1:0] dir, input logic dec);
        iAdrAll[ch*24 +: 24] = adr;
        iCntAll[ch*16 +: 16] = cnt;
        iDir[ch*2 +: 2]      = dir;
        iDec[ch]             = dec;
    endtask

    task automatic test_reset();
        iRst = 1'b1; iEn = 1'b1; iRotate = 1'b0; iDreq = 4'h0; iMask = 4'h0;
        iDir = 8'h00; iDec = 4'h0; iAdrAll = '0; iCntAll = '0;
        iMemData = 8'h00; iMemAck = 1'b0; iIoData = 8'h00;
        #1;
        n_checks++; if (oDack !== 4'h0 || oMemRW !== 2'b00 || oUpdStb !== 1'b0 || oTc !== 4'h0) begin
            n_fail++; $display("[TB] FAIL reset_outputs: got dack=%b rw=%b stb=%b tc=%b expected all 0", oDack, oMemRW, oUpdStb, oTc); end
        tick(); tick();
        iRst = 1'b0;
        tick();
        n_checks++; if (oDack !== 4'h0 || oMemData !== 8'h00 || oIoStb !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_idle: got dack=%b memdata=%h iostb=%b expected 0", oDack, oMemData, oIoStb); end
    endtask

    task automatic test_fixed_priority();
        applyStimulus(1, 24'h001234, 16'h0002, 2'b01, 1'b0);
        applyStimulus(3, 24'h000100, 16'h0009, 2'b01, 1'b0);
        iIoData = 8'h5A; iDreq = 4'b1010;
        tick();
        n_checks++; if (oDack !== 4'b0010) begin
            n_fail++; $display("[TB] FAIL fixed_dack: got %b expected 0010", oDack); end
        iDreq = 4'b0000;
        tick();
        n_checks++; if (oMemRW !== 2'b01 || oMemAdr !== 24'h001234) begin
            n_fail++; $display("[TB] FAIL fixed_mem: got rw=%b adr=%h expected 01 001234", oMemRW, oMemAdr); end
        n_checks++; if (oMemData !== 8'h5A) begin
            n_fail++; $display("[TB] FAIL fixed_memdata: got %h expected 5a", oMemData); end
        iMemAck = 1'b1;
        tick();
        iMemAck = 1'b0;
        n_checks++; if (oUpdStb !== 1'b1 || oUpdCh !== 2'd1 || oUpdAdr !== 24'h001235 || oUpdCnt !== 16'h0001) begin
            n_fail++; $display("[TB] FAIL fixed_upd: got stb=%b ch=%0d adr=%h cnt=%h expected 1 1 001235 0001", oUpdStb, oUpdCh, oUpdAdr, oUpdCnt); end
        n_checks++; if (oTc !== 4'h0 || oMemRW !== 2'b00) begin
            n_fail++; $display("[TB] FAIL fixed_notc: got tc=%b rw=%b expected 0000 00", oTc, oMemRW); end
        tick();
        n_checks++; if (oDack !== 4'h0 || oUpdStb !== 1'b0) begin
            n_fail++; $display("[TB] FAIL fixed_idle: got dack=%b stb=%b expected 0000 0", oDack, oUpdStb); end
    endtask

    task automatic test_dec_wrap();
        applyStimulus(2, 24'h070000, 16'h0005, 2'b10, 1'b1);
        iMemData = 8'hC3; iDreq = 4'b0100;
        tick();
        n_checks++; if (oDack !== 4'b0100) begin
            n_fail++; $display("[TB] FAIL dec_dack: got %b expected 0100", oDack); end
        iDreq = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (oMemRW !== 2'b10 || oMemAdr !== 24'h070000 || oIoStb !== 1'b0) begin
                n_fail++; $display("[TB] FAIL dec_hold%0d: got rw=%b adr=%h iostb=%b expected 10 070000 0", c, oMemRW, oMemAdr, oIoStb); end
        end
        iMemAck = 1'b1;
        tick();
        iMemAck = 1'b0;
        n_checks++; if (oUpdAdr !== 24'h07FFFF || oUpdCnt !== 16'h0004 || oUpdCh !== 2'd2) begin
            n_fail++; $display("[TB] FAIL dec_upd: got adr=%h cnt=%h ch=%0d expected 07ffff 0004 2", oUpdAdr, oUpdCnt, oUpdCh); end
        n_checks++; if (oIoStb !== 1'b1 || oIoData !== 8'hC3) begin
            n_fail++; $display("[TB] FAIL dec_io: got stb=%b data=%h expected 1 c3", oIoStb, oIoData); end
        tick();
        n_checks++; if (oIoStb !== 1'b0 || oDack !== 4'h0) begin
            n_fail++; $display("[TB] FAIL dec_end: got iostb=%b dack=%b expected 0 0000", oIoStb, oDack); end
    endtask

    task automatic test_tc_verify();
        applyStimulus(0, 24'h1200FF, 16'h0000, 2'b00, 1'b0);
        iDreq = 4'b0001;
        tick();
        n_checks++; if (oDack !== 4'b0001 || oMemRW !== 2'b00) begin
            n_fail++; $display("[TB] FAIL tc_grant: got dack=%b rw=%b expected 0001 00", oDack, oMemRW); end
        iDreq = 4'b0000;
        tick();
        n_checks++; if (oUpdStb !== 1'b1 || oUpdCnt !== 16'hFFFF || oUpdAdr !== 24'h120100 || oMemRW !== 2'b00) begin
            n_fail++; $display("[TB] FAIL tc_upd: got stb=%b cnt=%h adr=%h rw=%b expected 1 ffff 120100 00", oUpdStb, oUpdCnt, oUpdAdr, oMemRW); end
        n_checks++; if (oTc !== 4'b0001) begin
            n_fail++; $display("[TB] FAIL tc_pulse: got %b expected 0001", oTc); end
        tick();
        n_checks++; if (oTc !== 4'b0000 || oDack !== 4'h0) begin
            n_fail++; $display("[TB] FAIL tc_clear: got tc=%b dack=%b expected 0000 0000", oTc, oDack); end
    endtask

    task automatic test_rotating();
        logic [3:0] exp_rot [5];
        int waited;
        exp_rot[0] = 4'b0001; exp_rot[1] = 4'b0010; exp_rot[2] = 4'b0100;
        exp_rot[3] = 4'b1000; exp_rot[4] = 4'b0001;
        iDir = 8'h00; iCntAll = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        iRotate = 1'b1; iDreq = 4'b1111;
        for (int g = 0; g < 8; g++) begin
            if (g == 5) iRotate = 1'b0;
            tick();
            waited = 1;
            while (oDack === 4'h0 && waited < 10) begin tick(); waited++; end
            n_checks++; if (oDack !== ((g < 5) ? exp_rot[g] : 4'b0001)) begin
                n_fail++; $display("[TB] FAIL rot_grant%0d: got %b expected %b", g, oDack, (g < 5) ? exp_rot[g] : 4'b0001); end
            waited = 0;
            while (oDack !== 4'h0 && waited < 10) begin tick(); waited++; end
            n_checks++; if (oDack !== 4'h0) begin
                n_fail++; $display("[TB] FAIL rot_release%0d: got %b expected 0000", g, oDack); end
        end
        iDreq = 4'b0000;
        tick(); tick();
    endtask

    task automatic test_mask_mid();
        applyStimulus(1, 24'h002000, 16'h0010, 2'b01, 1'b0);
        iIoData = 8'hA5; iDreq = 4'b0010; iMask = 4'b0000;
        tick();
        n_checks++; if (oDack !== 4'b0010) begin
            n_fail++; $display("[TB] FAIL mask_dack: got %b expected 0010", oDack); end
        iMask = 4'b0010;
        tick();
        n_checks++; if (oMemRW !== 2'b01 || oMemData !== 8'hA5) begin
            n_fail++; $display("[TB] FAIL mask_mem: got rw=%b data=%h expected 01 a5", oMemRW, oMemData); end
        iMemAck = 1'b1;
        tick();
        iMemAck = 1'b0;
        n_checks++; if (oUpdStb !== 1'b1 || oUpdCh !== 2'd1 || oUpdAdr !== 24'h002001 || oUpdCnt !== 16'h000F) begin
            n_fail++; $display("[TB] FAIL mask_upd: got stb=%b ch=%0d adr=%h cnt=%h expected 1 1 002001 000f", oUpdStb, oUpdCh, oUpdAdr, oUpdCnt); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (oDack !== 4'h0) begin
                n_fail++; $display("[TB] FAIL mask_noregrant%0d: got %b expected 0000", c, oDack); end
        end
        iMask = 4'b0000; iEn = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++; if (oDack !== 4'h0) begin
                n_fail++; $display("[TB] FAIL en_off%0d: got %b expected 0000", c, oDack); end
        end
        iDreq = 4'b0000; iEn = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        applyStimulus(2, 24'h070000, 16'h0005, 2'b10, 1'b0);
        iRotate = 1'b0; iDreq = 4'b0100;
        tick();
        iDreq = 4'b0000;
        tick();
        n_checks++; if (oMemRW !== 2'b10) begin
            n_fail++; $display("[TB] FAIL rstmid_pre: got rw=%b expected 10", oMemRW); end
        #2 iRst = 1'b1;
        #1;
        n_checks++; if (oMemRW !== 2'b00 || oDack !== 4'h0 || oMemAdr !== 24'h0) begin
            n_fail++; $display("[TB] FAIL rstmid_now: got rw=%b dack=%b adr=%h expected 00 0000 000000", oMemRW, oDack, oMemAdr); end
        n_checks++; if (oMemData !== 8'h00 || oIoData !== 8'h00 || oUpdStb !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rstmid_data: got memdata=%h iodata=%h stb=%b expected 00 00 0", oMemData, oIoData, oUpdStb); end
        tick();
        iRst = 1'b0;
        iDir = 8'h00; iRotate = 1'b1; iDreq = 4'b1111;
        tick();
        n_checks++; if (oDack !== 4'b0001) begin
            n_fail++; $display("[TB] FAIL rstmid_rearb: got %b expected 0001", oDack); end
        iDreq = 4'b0000;
        tick(); tick(); tick();
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_dec_wrap();
        test_tc_verify();
        test_rotating();
        test_mask_mid();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
